// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write/status outputs of the program loader.
// The loader itself connects through the slave modport.
interface prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
);
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              CPU_RST;
    logic              LOAD_DONE;
    logic              LOAD_ERR;

    modport master (
        output RX_DATA, RX_VALID,
        input  WR_EN, WR_ADDR, WR_DATA, CPU_RST, LOAD_DONE, LOAD_ERR
    );

    modport slave (
        input  RX_DATA, RX_VALID,
        output WR_EN, WR_ADDR, WR_DATA, CPU_RST, LOAD_DONE, LOAD_ERR
    );
endinterface

// File: rtl/prog_loader.sv
// Parses SYNC/LEN/3-byte-word/CSUM frames from a UART byte strobe and writes 18-bit words
// into program memory, holding the MCU in reset until a frame loads with a good checksum.
module prog_loader #(
    parameter int         ADDR_W  = 10,
    parameter int         DATA_W  = 18,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1_000_000
) (
    input logic          CLK,
    input logic          RST,
    prog_loader_if.slave bus
);
    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [15:0]       MAX_LEN  = 16'(2 ** ADDR_W);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_B0     = 3'd3,
        S_B1     = 3'd4,
        S_B2     = 3'd5,
        S_CSUM   = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic [7:0]        len_hi_r, len_hi_s;
    logic [CNT_W-1:0]  len_r, len_s;
    logic [CNT_W-1:0]  idx_r, idx_s;
    logic [7:0]        sum_r, sum_s;
    logic [1:0]        b0_r, b0_s;
    logic [7:0]        b1_r, b1_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0] wr_data_r, wr_data_s;
    logic              cpu_rst_r, cpu_rst_s;
    logic              done_r, done_s;
    logic              err_r, err_s;

    logic [15:0]       frame_len_s;
    logic [CNT_W-1:0]  idx_inc_s;

    assign frame_len_s = {len_hi_r, bus.RX_DATA};
    assign idx_inc_s   = idx_r + CNT_W'(1);

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_s   = state_r;
        len_hi_s  = len_hi_r;
        len_s     = len_r;
        idx_s     = idx_r;
        sum_s     = sum_r;
        b0_s      = b0_r;
        b1_s      = b1_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        cpu_rst_s = cpu_rst_r;
        done_s    = 1'b0;
        err_s     = err_r;

        if (state_r == S_IDLE || bus.RX_VALID) begin
            tmo_s = {TMO_W{1'b0}};
        end else begin
            tmo_s = tmo_r + TMO_W'(1);
        end

        if (bus.RX_VALID) begin
            case (state_r)
                S_IDLE: begin
                    if (bus.RX_DATA == SYNC) begin
                        state_s   = S_LEN_HI;
                        cpu_rst_s = 1'b1;
                        err_s     = 1'b0;
                        idx_s     = {CNT_W{1'b0}};
                        sum_s     = 8'd0;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LEN_HI: begin
                    len_hi_s = bus.RX_DATA;
                    state_s  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (frame_len_s == 16'd0 || frame_len_s > MAX_LEN) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        len_s   = frame_len_s[CNT_W-1:0];
                        state_s = S_B0;
                    end
                end
                S_B0: begin
                    b0_s    = bus.RX_DATA[1:0];
                    sum_s   = sum_r + bus.RX_DATA;
                    state_s = S_B1;
                end
                S_B1: begin
                    b1_s    = bus.RX_DATA;
                    sum_s   = sum_r + bus.RX_DATA;
                    state_s = S_B2;
                end
                S_B2: begin
                    sum_s     = sum_r + bus.RX_DATA;
                    wr_en_s   = 1'b1;
                    wr_addr_s = idx_r[ADDR_W-1:0];
                    wr_data_s = {b0_r, b1_r, bus.RX_DATA};
                    idx_s     = idx_inc_s;
                    if (idx_inc_s == len_r) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_B0;
                    end
                end
                S_CSUM: begin
                    if (bus.RX_DATA == sum_r) begin
                        done_s    = 1'b1;
                        cpu_rst_s = 1'b0;
                    end else begin
                        err_s = 1'b1;
                    end
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else if (state_r != S_IDLE && tmo_r == TMO_LAST) begin
            // Stalled mid-frame: abandon the load but keep the MCU held in reset.
            err_s   = 1'b1;
            state_s = S_IDLE;
            tmo_s   = {TMO_W{1'b0}};
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= S_IDLE;
            len_hi_r  <= 8'd0;
            len_r     <= {CNT_W{1'b0}};
            idx_r     <= {CNT_W{1'b0}};
            sum_r     <= 8'd0;
            b0_r      <= 2'd0;
            b1_r      <= 8'd0;
            tmo_r     <= {TMO_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            cpu_rst_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            len_hi_r  <= len_hi_s;
            len_r     <= len_s;
            idx_r     <= idx_s;
            sum_r     <= sum_s;
            b0_r      <= b0_s;
            b1_r      <= b1_s;
            tmo_r     <= tmo_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            cpu_rst_r <= cpu_rst_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign bus.WR_EN     = wr_en_r;
    assign bus.WR_ADDR   = wr_addr_r;
    assign bus.WR_DATA   = wr_data_r;
    assign bus.CPU_RST   = cpu_rst_r;
    assign bus.LOAD_DONE = done_r;
    assign bus.LOAD_ERR  = err_r;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: constant frame table, cycle-exact hand sequences,
// and random frames scored against a frame-level parsing model.
module tb_prog_loader;
    localparam int         ADDR_W  = 10;
    localparam int         DATA_W  = 18;
    localparam int         TIMEOUT = 100;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string        name;
        logic [127:0] raw;
        int           nb;
        int           n_wr;
        logic [27:0]  first_wr;
        logic [27:0]  last_wr;
        int           n_done;
        logic         err;
        logic         cpu;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [27:0] got_wr[$];
    int          got_done = 0;

    logic [27:0] exp_wr[$];
    int          m_done;
    logic        m_err;
    logic        m_cpu;

    vec_t        tbl[6];

    // Collect every write and done pulse the DUT produces.
    always @(negedge CLK) begin
        if (bus.WR_EN === 1'b1) got_wr.push_back({bus.WR_ADDR, bus.WR_DATA});
        if (bus.LOAD_DONE === 1'b1) got_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Present one byte for exactly one clock; returns at the negedge after it was captured.
    task automatic strobe(input logic [7:0] b);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input bq_t q, input int maxgap);
        foreach (q[j]) begin
            strobe(q[j]);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
        idle(4);
    endtask

    function automatic bq_t unpack(input logic [127:0] raw, input int nb);
        bq_t q;
        for (int j = 0; j < nb; j++) q.push_back(raw[8*(nb-1-j) +: 8]);
        return q;
    endfunction

    // Frame with n random words; bad lengths produce only the header.
    function automatic bq_t build(input int n, input bit good_csum);
        bq_t q;
        int  s = 0;
        logic [7:0] v;
        q.push_back(SYNC);
        q.push_back(8'((n >> 8) & 255));
        q.push_back(8'(n & 255));
        if (n >= 1 && n <= 1024) begin
            for (int k = 0; k < 3 * n; k++) begin
                v = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
                q.push_back(v);
                s += int'(v);
            end
            q.push_back(8'((s + (good_csum ? 0 : 1)) % 256));
        end
        return q;
    endfunction

    // Frame-level reference: scan for SYNC, read N, take 3N bytes as words, compare checksum.
    task automatic model_run(input bq_t b);
        int i = 0;
        int n;
        int s;
        logic [17:0] w;
        while (i < b.size()) begin
            if (b[i] != SYNC) begin
                i++;
            end else begin
                m_err = 1'b0;
                m_cpu = 1'b1;
                n = int'(b[i+1]) * 256 + int'(b[i+2]);
                i += 3;
                if (n < 1 || n > 1024) begin
                    m_err = 1'b1;
                end else begin
                    s = 0;
                    for (int k = 0; k < n; k++) begin
                        w = {b[i][1:0], b[i+1], b[i+2]};
                        exp_wr.push_back({10'(k), w});
                        s += int'(b[i]) + int'(b[i+1]) + int'(b[i+2]);
                        i += 3;
                    end
                    if (int'(b[i]) == s % 256) begin
                        m_done++;
                        m_cpu = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    i++;
                end
            end
        end
    endtask

    task automatic run_model_frame(input string name, input bq_t q, input int maxgap);
        int mism = 0;
        exp_wr.delete();
        m_done = 0;
        got_wr.delete();
        got_done = 0;
        model_run(q);
        send(q, maxgap);
        chk({name, " nwr"}, got_wr.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++)
            if (got_wr[k] !== exp_wr[k]) mism++;
        chk({name, " wr mismatches"}, mism, 0);
        chk({name, " done"}, got_done, m_done);
        chk({name, " err"}, bus.LOAD_ERR, m_err);
        chk({name, " cpu_rst"}, bus.CPU_RST, m_cpu);
    endtask

    initial begin
        bq_t q;
        tbl[0] = '{"happy", 128'hA5_00_02_03_12_34_00_00_FF_48, 10, 2,
                   {10'h000, 18'h31234}, {10'h001, 18'h000FF}, 1, 1'b0, 1'b0};
        tbl[1] = '{"bad_csum", 128'hA5_00_02_03_12_34_00_00_FF_49, 10, 2,
                   {10'h000, 18'h31234}, {10'h001, 18'h000FF}, 0, 1'b1, 1'b1};
        tbl[2] = '{"recover", 128'hA5_00_02_03_12_34_00_00_FF_48, 10, 2,
                   {10'h000, 18'h31234}, {10'h001, 18'h000FF}, 1, 1'b0, 1'b0};
        tbl[3] = '{"len_zero", 128'hA5_00_00, 3, 0, 28'd0, 28'd0, 0, 1'b1, 1'b1};
        tbl[4] = '{"len_1025", 128'hA5_04_01, 3, 0, 28'd0, 28'd0, 0, 1'b1, 1'b1};
        tbl[5] = '{"noise_sync", 128'h00_FF_A5_00_01_FD_A5_12_B4, 9, 1,
                   {10'h000, 18'h1A512}, {10'h000, 18'h1A512}, 1, 1'b0, 1'b0};

        RST = 1'b1;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA = 8'h00;
        idle(3);
        chk("reset wr_en", bus.WR_EN, 1'b0);
        chk("reset wr_addr", bus.WR_ADDR, 10'h000);
        chk("reset wr_data", bus.WR_DATA, 18'h00000);
        chk("reset cpu_rst", bus.CPU_RST, 1'b0);
        chk("reset done", bus.LOAD_DONE, 1'b0);
        chk("reset err", bus.LOAD_ERR, 1'b0);
        RST = 1'b0;
        idle(2);

        // Constant frame table, bytes back-to-back.
        for (int t = 0; t < 6; t++) begin
            got_wr.delete();
            got_done = 0;
            send(unpack(tbl[t].raw, tbl[t].nb), 0);
            chk({tbl[t].name, " nwr"}, got_wr.size(), tbl[t].n_wr);
            if (tbl[t].n_wr > 0) begin
                chk({tbl[t].name, " first wr"}, got_wr[0], tbl[t].first_wr);
                chk({tbl[t].name, " last wr"}, got_wr[$], tbl[t].last_wr);
            end
            chk({tbl[t].name, " done"}, got_done, tbl[t].n_done);
            chk({tbl[t].name, " err"}, bus.LOAD_ERR, tbl[t].err);
            chk({tbl[t].name, " cpu_rst"}, bus.CPU_RST, tbl[t].cpu);
        end

        // Cycle-exact output timing on the happy frame.
        strobe(8'hA5);
        chk("timing cpu_rst rise", bus.CPU_RST, 1'b1);
        idle(1);
        strobe(8'h00); strobe(8'h02);
        strobe(8'h03); strobe(8'h12); strobe(8'h34);
        chk("timing wr_en w0", bus.WR_EN, 1'b1);
        chk("timing wr_addr w0", bus.WR_ADDR, 10'h000);
        chk("timing wr_data w0", bus.WR_DATA, 18'h31234);
        idle(1);
        chk("timing wr_en pulse", bus.WR_EN, 1'b0);
        chk("timing wr_data hold", bus.WR_DATA, 18'h31234);
        strobe(8'h00); strobe(8'h00); strobe(8'hFF);
        chk("timing wr_addr w1", bus.WR_ADDR, 10'h001);
        strobe(8'h48);
        chk("timing done pulse", bus.LOAD_DONE, 1'b1);
        chk("timing cpu_rst fall", bus.CPU_RST, 1'b0);
        idle(1);
        chk("timing done one cycle", bus.LOAD_DONE, 1'b0);

        // Timeout mid-frame.
        got_wr.delete();
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'h03);
        idle(TIMEOUT - 5);
        chk("timeout early err", bus.LOAD_ERR, 1'b0);
        idle(10);
        chk("timeout err", bus.LOAD_ERR, 1'b1);
        chk("timeout cpu_rst", bus.CPU_RST, 1'b1);
        chk("timeout no write", got_wr.size(), 0);
        got_wr.delete();
        got_done = 0;
        send(unpack(tbl[0].raw, tbl[0].nb), 0);
        chk("after timeout nwr", got_wr.size(), 2);
        chk("after timeout done", got_done, 1);
        chk("after timeout err", bus.LOAD_ERR, 1'b0);

        // Reset while waiting for B1.
        strobe(8'hA5); strobe(8'h00); strobe(8'h01); strobe(8'hFD);
        RST = 1'b1;
        idle(1);
        chk("midrst wr_en", bus.WR_EN, 1'b0);
        chk("midrst wr_addr", bus.WR_ADDR, 10'h000);
        chk("midrst wr_data", bus.WR_DATA, 18'h00000);
        chk("midrst cpu_rst", bus.CPU_RST, 1'b0);
        chk("midrst done", bus.LOAD_DONE, 1'b0);
        chk("midrst err", bus.LOAD_ERR, 1'b0);
        RST = 1'b0;
        idle(1);
        m_err = 1'b0;
        m_cpu = 1'b0;

        // Full 1024-word image.
        q = build(1024, 1'b1);
        run_model_frame("full1024", q, 0);
        chk("full1024 last addr", got_wr.size() > 0 ? 32'(got_wr[$][27:18]) : 32'hFFFF_FFFF, 32'h3FF);

        // Random frames with noise, gaps, bad lengths and bad checksums.
        for (int f = 0; f < 20; f++) begin
            bq_t r;
            int  sel;
            logic [7:0] nz;
            repeat ($urandom_range(0, 2)) begin
                nz = 8'($urandom_range(0, 255));
                r.push_back(nz == SYNC ? 8'h00 : nz);
            end
            sel = $urandom_range(0, 7);
            if (sel == 0) q = build(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 65535), 1'b1);
            else q = build($urandom_range(1, 6), sel != 1 && sel != 2);
            foreach (q[j]) r.push_back(q[j]);
            run_model_frame($sformatf("rnd%0d", f), r, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
